// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared encodings for the pipeline sequencing controller
// Contents: FSM state encoding, NOP bubble encoding, register-address width,
//           and the packed bundle of stage-register load/flush controls.
package pipe_pkg;

  localparam int REG_AW = 3;

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] MEM_WAIT = 2'd1;
  localparam logic [1:0] MUL_BUSY = 2'd2;
  localparam logic [1:0] HALT     = 2'd3;

  // Instruction word the stage registers load when their flush control is set.
  localparam logic [15:0] NOP_INSTR = 16'h0000;

  typedef struct packed {
    logic pc;
    logic ifid;
    logic idex;
    logic exmem;
    logic memwb;
    logic ifid_flush;
    logic idex_flush;
  } pipe_ctl_t;

  localparam pipe_ctl_t CTL_FLOW   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  localparam pipe_ctl_t CTL_FREEZE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  // Hold PC and IF/ID, push a bubble into ID/EX, let the back end drain.
  localparam pipe_ctl_t CTL_BUBBLE = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  localparam pipe_ctl_t CTL_SQUASH = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use hazard comparator
// Ports: id_rs1/id_rs2 + id_use_rs1/id_use_rs2 (ID sources and their use flags),
//        ex_rd + ex_is_load (EX destination and load flag),
//        load_use (ID instruction needs a value the EX load has not produced yet).
module hazard_detect #(
  parameter int REG_AW = 3
) (
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_is_load,
  output logic              load_use
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = id_use_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit = id_use_rs2 && (id_rs2 == ex_rd);

  // R0 is hard-wired zero, so a load targeting it never creates a dependency.
  assign load_use = ex_is_load && (ex_rd != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline sequencing controller for the 16-bit pipelined CPU
// Ports: clk, rst_n (async active-low);
//        id_* / ex_* / mem_* hazard and event inputs from the datapath;
//        *_ld, ifid_flush, idex_flush stage-register controls (combinational);
//        mul_done, halted, err, stall_cnt status.
module pipe_ctrl #(
  parameter int MUL_CYCLES  = 4,
  parameter int MEM_TIMEOUT = 255,
  parameter int REG_AW      = pipe_pkg::REG_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              id_halt,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_is_load,
  input  logic              ex_br_taken,
  input  logic              ex_mul_start,
  input  logic              mem_req,
  input  logic              mem_ready,
  output logic              pc_ld,
  output logic              ifid_ld,
  output logic              idex_ld,
  output logic              exmem_ld,
  output logic              memwb_ld,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              mul_done,
  output logic              halted,
  output logic              err,
  output logic [15:0]       stall_cnt
);

  import pipe_pkg::*;

  // mul_cnt counts the frozen MUL_BUSY cycles still to go before the done
  // cycle; with the issue cycle that gives MUL_CYCLES-1 frozen cycles and the
  // multiply leaves EX in the done cycle, MUL_CYCLES cycles after issue.
  localparam logic [3:0] MUL_LOAD   = 4'(MUL_CYCLES - 2);
  localparam logic [7:0] WAIT_LIMIT = 8'(MEM_TIMEOUT);

  logic [1:0]  state_q,     state_d;
  logic [3:0]  mul_cnt_q,   mul_cnt_d;
  logic [7:0]  wait_cnt_q,  wait_cnt_d;
  logic        err_q,       err_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  pipe_ctl_t ctl;
  logic      load_use;
  logic      run_eval;
  logic      skip_mul;
  logic      mul_done_c;

  hazard_detect #(.REG_AW(REG_AW)) u_hazard (
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_use_rs1 (id_use_rs1),
    .id_use_rs2 (id_use_rs2),
    .ex_rd      (ex_rd),
    .ex_is_load (ex_is_load),
    .load_use   (load_use)
  );

  always_comb begin
    state_d    = state_q;
    mul_cnt_d  = mul_cnt_q;
    wait_cnt_d = wait_cnt_q;
    err_d      = err_q;
    ctl        = CTL_FREEZE;
    run_eval   = 1'b0;
    skip_mul   = 1'b0;
    mul_done_c = 1'b0;

    case (state_q)
      RUN: run_eval = 1'b1;
      MEM_WAIT: begin
        if (mem_ready) begin
          run_eval = 1'b1;
        end else if (wait_cnt_q == WAIT_LIMIT) begin
          state_d = HALT;
          err_d   = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      MUL_BUSY: begin
        if (mul_cnt_q == 4'd0) begin
          // The multiply is still presenting ex_mul_start; it must not re-issue.
          mul_done_c = 1'b1;
          run_eval   = 1'b1;
          skip_mul   = 1'b1;
        end else begin
          mul_cnt_d = mul_cnt_q - 4'd1;
        end
      end
      default: ctl = CTL_BUBBLE;
    endcase

    // Shared RUN decision, also taken in the cycle a wait or multiply retires,
    // so a back-to-back event is picked up without an idle cycle in between.
    if (run_eval) begin
      state_d = RUN;
      if (mem_req && !mem_ready) begin
        ctl        = CTL_FREEZE;
        state_d    = MEM_WAIT;
        wait_cnt_d = 8'd1;
      end else if (ex_mul_start && !skip_mul) begin
        ctl       = CTL_FREEZE;
        state_d   = MUL_BUSY;
        mul_cnt_d = MUL_LOAD;
      end else if (ex_br_taken) begin
        ctl = CTL_SQUASH;
      end else if (id_halt) begin
        ctl     = CTL_BUBBLE;
        state_d = HALT;
      end else if (load_use) begin
        ctl = CTL_BUBBLE;
      end else begin
        ctl = CTL_FLOW;
      end
    end

    stall_cnt_d = stall_cnt_q;
    if ((state_q != HALT) && !ctl.pc && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      mul_cnt_q   <= 4'd0;
      wait_cnt_q  <= 8'd0;
      err_q       <= 1'b0;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      mul_cnt_q   <= mul_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Outputs are gated by rst_n so they drop the moment reset is asserted,
  // without waiting for the flops to clear.
  assign pc_ld      = rst_n && ctl.pc;
  assign ifid_ld    = rst_n && ctl.ifid;
  assign idex_ld    = rst_n && ctl.idex;
  assign exmem_ld   = rst_n && ctl.exmem;
  assign memwb_ld   = rst_n && ctl.memwb;
  assign ifid_flush = rst_n && ctl.ifid_flush;
  assign idex_flush = rst_n && ctl.idex_flush;
  assign mul_done   = rst_n && mul_done_c;
  assign halted     = rst_n && (state_q == HALT);
  assign err        = rst_n && err_q;
  assign stall_cnt  = rst_n ? stall_cnt_q : 16'd0;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - self-checking bench for pipe_ctrl
module tb_pipe_ctrl;

  localparam int MUL_CYCLES  = 4;
  localparam int MEM_TIMEOUT = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] id_rs1, id_rs2, ex_rd;
  logic       id_use_rs1, id_use_rs2, id_halt;
  logic       ex_is_load, ex_br_taken, ex_mul_start, mem_req, mem_ready;
  logic       pc_ld, ifid_ld, idex_ld, exmem_ld, memwb_ld, ifid_flush, idex_flush;
  logic       mul_done, halted, err;
  logic [15:0] stall_cnt;

  int checks   = 0;
  int failures = 0;

  pipe_ctrl #(.MUL_CYCLES(MUL_CYCLES), .MEM_TIMEOUT(MEM_TIMEOUT), .REG_AW(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_halt(id_halt), .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_br_taken(ex_br_taken),
    .ex_mul_start(ex_mul_start), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_ld(pc_ld), .ifid_ld(ifid_ld), .idex_ld(idex_ld), .exmem_ld(exmem_ld),
    .memwb_ld(memwb_ld), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .mul_done(mul_done), .halted(halted), .err(err), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference ----------------
  // Control vector order: {pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush}
  localparam logic [6:0] V_FLOW   = 7'b1111100;
  localparam logic [6:0] V_FREEZE = 7'b0000000;
  localparam logic [6:0] V_BUBBLE = 7'b0011101;
  localparam logic [6:0] V_SQUASH = 7'b1111111;

  bit m_halt     = 0;
  bit m_err      = 0;
  int m_wait     = 0;   // consecutive not-ready cycles so far (0: no wait pending)
  int m_mul_left = 0;   // cycles of EX occupancy left after the issue cycle
  int m_stall    = 0;

  function automatic bit model_load_use();
    if (!ex_is_load || ex_rd == 0) return 0;
    return (id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd);
  endfunction

  // act: 0 none, 1 begin memory wait, 2 begin multiply, 3 enter halt
  task automatic run_rules(input bit skip_mul, output logic [6:0] v, output int act);
    act = 0;
    if (mem_req && !mem_ready)          begin v = V_FREEZE; act = 1; end
    else if (ex_mul_start && !skip_mul) begin v = V_FREEZE; act = 2; end
    else if (ex_br_taken)               v = V_SQUASH;
    else if (id_halt)                   begin v = V_BUBBLE; act = 3; end
    else if (model_load_use())          v = V_BUBBLE;
    else                                v = V_FLOW;
  endtask

  always @(negedge clk) begin
    logic [6:0] v;
    logic [6:0] got;
    int act;
    bit e_done, timeout, was_halt;
    got = {pc_ld, ifid_ld, idex_ld, exmem_ld, memwb_ld, ifid_flush, idex_flush};
    if (!rst_n) begin
      chk("reset_outputs", int'({got, mul_done, halted, err, stall_cnt}), 0);
      m_halt = 0; m_err = 0; m_wait = 0; m_mul_left = 0; m_stall = 0;
    end else begin
      e_done = 0; timeout = 0; act = 0; was_halt = m_halt; v = V_FREEZE;
      if (m_halt) begin
        v = V_BUBBLE;
      end else if (m_mul_left > 0) begin
        if (m_mul_left == 1) begin
          e_done = 1; m_mul_left = 0; run_rules(1, v, act);
        end else begin
          m_mul_left--;
        end
      end else if (m_wait > 0) begin
        if (mem_ready) begin
          m_wait = 0; run_rules(0, v, act);
        end else if (m_wait == MEM_TIMEOUT) begin
          m_wait = 0; timeout = 1;
        end else begin
          m_wait++;
        end
      end else begin
        run_rules(0, v, act);
      end
      chk("model_ctl", int'(got), int'(v));
      chk("model_mul_done", int'(mul_done), int'(e_done));
      chk("model_halted", int'(halted), int'(m_halt));
      chk("model_err", int'(err), int'(m_err));
      chk("model_stall_cnt", int'(stall_cnt), m_stall);
      if (!was_halt && !v[6] && m_stall < 65535) m_stall++;
      if (timeout) begin m_halt = 1; m_err = 1; end
      case (act)
        1: m_wait = 1;
        2: m_mul_left = MUL_CYCLES - 1;
        3: m_halt = 1;
        default: ;
      endcase
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0; id_halt = 0;
    ex_rd = 0; ex_is_load = 0; ex_br_taken = 0; ex_mul_start = 0;
    mem_req = 0; mem_ready = 1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_load_use(input logic [2:0] rd);
    ex_is_load = 1; ex_rd = rd; id_use_rs2 = 1; id_rs2 = 3;
  endtask

  task automatic reset_dut();
    rst_n = 0;
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic rand_inputs();
    id_rs1 = 3'($urandom_range(0, 3)); id_rs2 = 3'($urandom_range(0, 3));
    id_use_rs1 = 1'($urandom_range(0, 1)); id_use_rs2 = 1'($urandom_range(0, 1));
    ex_rd = 3'($urandom_range(0, 3)); ex_is_load = ($urandom_range(0, 2) == 0);
    ex_br_taken = ($urandom_range(0, 5) == 0); ex_mul_start = ($urandom_range(0, 11) == 0);
    id_halt = ($urandom_range(0, 149) == 0);
    mem_req = ($urandom_range(0, 2) == 0); mem_ready = ($urandom_range(0, 3) != 0);
  endtask

  initial begin
    idle();
    rst_n = 0;
    #3;
    chk("reset_pc_ld", int'(pc_ld), 0);
    chk("reset_idex_ld", int'(idex_ld), 0);
    chk("reset_stall_cnt", int'(stall_cnt), 0);
    @(posedge clk); #1; rst_n = 1;

    @(negedge clk);
    chk("run_pc_ld", int'(pc_ld), 1);
    chk("run_flush", int'({ifid_flush, idex_flush}), 0);

    // load-use on rs2
    tick(); set_load_use(3);
    @(negedge clk);
    chk("lu_pc_ld", int'(pc_ld), 0);
    chk("lu_ifid_ld", int'(ifid_ld), 0);
    chk("lu_idex_flush", int'(idex_flush), 1);
    chk("lu_back_ld", int'({idex_ld, exmem_ld, memwb_ld}), 7);
    chk("lu_stall_before", int'(stall_cnt), 0);
    // same sources with ex_rd=0: R0 never stalls
    tick(); set_load_use(0); id_rs2 = 0;
    @(negedge clk);
    chk("lu_stall_after", int'(stall_cnt), 1);
    chk("r0_pc_ld", int'(pc_ld), 1);

    // taken branch beats a simultaneous load-use
    tick(); set_load_use(3); ex_br_taken = 1;
    @(negedge clk);
    chk("br_all_ld", int'({pc_ld, ifid_ld, idex_ld, exmem_ld, memwb_ld}), 31);
    chk("br_flush", int'({ifid_flush, idex_flush}), 3);
    tick(); idle();
    @(negedge clk);
    chk("br_stall_unchanged", int'(stall_cnt), 1);

    // multiply: 3 frozen cycles, done on the 4th
    tick(); ex_mul_start = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mul_frozen", int'({pc_ld, ifid_ld, idex_ld, exmem_ld, memwb_ld, mul_done}), 0);
      tick();
    end
    @(negedge clk);
    chk("mul_done", int'(mul_done), 1);
    chk("mul_done_ld", int'({pc_ld, memwb_ld}), 3);
    tick(); idle();
    @(negedge clk);
    chk("mul_stall_cnt", int'(stall_cnt), 4);
    chk("mul_done_pulse", int'(mul_done), 0);

    // memory wait of 5 cycles then ready
    tick(); mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("memw_frozen", int'({pc_ld, ifid_ld, idex_ld, exmem_ld, memwb_ld}), 0);
      tick();
    end
    mem_ready = 1;
    @(negedge clk);
    chk("memw_ready_ld", int'({pc_ld, ifid_ld, idex_ld, exmem_ld, memwb_ld}), 31);
    tick(); idle();
    @(negedge clk);
    chk("memw_stall_cnt", int'(stall_cnt), 9);

    // timeout: entry cycle plus MEM_TIMEOUT waiting cycles, then HALT with err
    tick(); mem_req = 1; mem_ready = 0;
    for (int i = 0; i < MEM_TIMEOUT + 1; i++) begin
      @(negedge clk);
      chk("to_not_halted", int'({halted, err, pc_ld}), 0);
      tick();
    end
    @(negedge clk);
    chk("to_halted", int'(halted), 1);
    chk("to_err", int'(err), 1);
    chk("to_halt_ctl", int'({pc_ld, ifid_ld, idex_ld, idex_flush}), 3);
    chk("to_stall_cnt", int'(stall_cnt), 18);
    tick();
    @(negedge clk);
    chk("halt_stall_hold", int'(stall_cnt), 18);
    chk("err_sticky", int'(err), 1);

    // asynchronous reset in the middle of HALT
    #2; rst_n = 0; #1;
    chk("async_halted", int'(halted), 0);
    chk("async_err", int'(err), 0);
    chk("async_idex_ld", int'(idex_ld), 0);
    chk("async_stall", int'(stall_cnt), 0);
    @(negedge clk); @(posedge clk); #1; rst_n = 1; idle();

    // HLT in ID
    id_halt = 1;
    @(negedge clk);
    chk("hlt_pc_ld", int'(pc_ld), 0);
    chk("hlt_not_yet", int'(halted), 0);
    tick(); id_halt = 0;
    @(negedge clk);
    chk("hlt_halted", int'(halted), 1);
    for (int i = 0; i < 20; i++) begin
      tick(); rand_inputs();
      @(negedge clk);
      chk("hlt_pc_forever", int'(pc_ld), 0);
    end
    tick(); reset_dut(); idle();

    // saturation via a permanently held load-use
    set_load_use(3);
    repeat (65540) tick();
    @(negedge clk);
    chk("sat_value", int'(stall_cnt), 65535);
    tick();
    @(negedge clk);
    chk("sat_hold", int'(stall_cnt), 65535);
    tick(); reset_dut(); idle();

    // randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      rand_inputs();
      if ((m_halt && $urandom_range(0, 7) == 0) || $urandom_range(0, 499) == 0) reset_dut();
      else tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
